// File: rtl/bucket_reduce.sv
// bucket_reduce: running-sum reduction of a bucket RAM, S = sum j*B[j] mod MOD.
// Buckets are read from NB-1 down to 1. Each returned datum is added into
// `running`, then `running` is added into `total`. Bucket j therefore
// contributes j times to `total`, so no multiplier is needed.
module bucket_reduce #(
    parameter int              NB     = 32,
    parameter int              AWIDTH = 5,
    parameter int              W      = 32,
    parameter logic [W-1:0]    MOD    = 32'hFFFFFFFB
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [AWIDTH-1:0] B_i_address0,
    output logic              B_i_ce0,
    input  logic [W-1:0]      B_i_q0,
    output logic [W-1:0]      sum_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_DONE
    } state_t;

    localparam logic [AWIDTH-1:0] TOP_ADDR = AWIDTH'(NB - 1);
    localparam logic [AWIDTH-1:0] ONE_ADDR = AWIDTH'(1);

    state_t            state, state_next;
    logic [AWIDTH-1:0] cnt;
    logic [W-1:0]      running, total;
    logic [W-1:0]      running_acc, total_acc;
    logic              acc_en;

    // Single conditional subtract; exact only when both inputs are below MOD.
    function automatic logic [W-1:0] modadd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MOD})
            s = s - {1'b0, MOD};
        return s[W-1:0];
    endfunction

    // Chained accumulate step: new running feeds the total update in the same cycle.
    always_comb begin
        running_acc = modadd(running, B_i_q0);
        total_acc   = modadd(total, running_acc);
        // Data arrives one cycle after its address; the first FETCH cycle has none.
        acc_en      = ((state == S_FETCH) && (cnt != TOP_ADDR)) || (state == S_LAST);
    end

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next   = state;
        ap_idle      = 1'b0;
        ap_done      = 1'b0;
        B_i_ce0      = 1'b0;
        B_i_address0 = '0;
        unique case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                B_i_ce0      = 1'b1;
                B_i_address0 = cnt;
                if (cnt == ONE_ADDR)
                    state_next = S_LAST;
            end
            S_LAST: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                ap_done    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        ap_ready = ap_done;
    end

    // Address counter, accumulators and result register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt     <= '0;
            running <= '0;
            total   <= '0;
            sum_out <= '0;
        end else begin
            if ((state == S_IDLE) && ap_start) begin
                cnt     <= TOP_ADDR;
                running <= '0;
                total   <= '0;
            end else begin
                if ((state == S_FETCH) && (cnt != ONE_ADDR))
                    cnt <= cnt - ONE_ADDR;
                if (acc_en) begin
                    running <= running_acc;
                    total   <= total_acc;
                end
            end
            // Captured from the final accumulate so sum_out is already valid in DONE.
            if (state == S_LAST)
                sum_out <= total_acc;
        end
    end

endmodule

// File: tb/tb_bucket_reduce.sv
// Directed self-checking bench for bucket_reduce with a registered bucket RAM model.
module tb_bucket_reduce;

    localparam logic [31:0] MOD = 32'hFFFFFFFB;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [4:0]  B_i_address0;
    logic        B_i_ce0;
    logic [31:0] B_i_q0;
    logic [31:0] sum_out;

    logic [31:0] mem [32];

    int total_n = 0;
    int bad_n   = 0;

    bucket_reduce #(
        .NB(32),
        .AWIDTH(5),
        .W(32),
        .MOD(32'hFFFFFFFB)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_start(ap_start),
        .ap_done(ap_done),
        .ap_idle(ap_idle),
        .ap_ready(ap_ready),
        .B_i_address0(B_i_address0),
        .B_i_ce0(B_i_ce0),
        .B_i_q0(B_i_q0),
        .sum_out(sum_out)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Bucket RAM: registered read, one cycle latency.
    always_ff @(posedge ap_clk) begin
        if (B_i_ce0)
            B_i_q0 <= mem[B_i_address0];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    // One run started by a single-cycle ap_start pulse; cycle 0 is the sampling cycle.
    task automatic run_check(input string tag, input logic [31:0] exp_sum);
        logic [4:0] exp_addr;
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            if (k <= 31) begin
                exp_addr = 5'(32 - k);
                chk({tag, "_addr"}, {58'd0, B_i_ce0, B_i_address0}, {58'd0, 1'b1, exp_addr});
            end else begin
                chk({tag, "_ce_off"}, {63'd0, B_i_ce0}, 64'd0);
            end
            chk({tag, "_no_addr0"}, {63'd0, B_i_ce0 && (B_i_address0 == 5'd0)}, 64'd0);
            chk({tag, "_done"}, {62'd0, ap_done, ap_ready}, {62'd0, k == 33, k == 33});
            chk({tag, "_total_lt_mod"}, {63'd0, dut.total < MOD}, 64'd1);
            if (k == 33)
                chk({tag, "_sum"}, {32'd0, sum_out}, {32'd0, exp_sum});
        end
    endtask

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        fill(32'd0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // 1: reset state holds for 50 idle cycles
        for (int c = 0; c < 50; c++) begin
            @(negedge ap_clk);
            chk("idle_hold", {32'd0, ap_idle, ap_done, B_i_ce0, ap_ready, sum_out[27:0]},
                {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0});
            chk("idle_sum", {32'd0, sum_out}, 64'd0);
        end

        // 2: all zero buckets
        run_check("zero", 32'd0);

        // 3: all ones -> 1+2+...+31
        fill(32'd1);
        run_check("ones", 32'd496);

        // 4: only bucket 0 populated; it must never be read
        fill(32'd0);
        mem[0] = 32'hDEADBEEF;
        run_check("b0_only", 32'd0);

        // 5: 31*(MOD-1) + 1*2 = -29 mod MOD
        fill(32'd0);
        mem[31] = MOD - 32'd1;
        mem[1]  = 32'd2;
        run_check("wrap", 32'hFFFFFFDE);

        // 6: reset mid-run, then back-to-back runs with ap_start held high
        fill(32'd1);
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            if (k < 10)
                chk("pre_rst_no_done", {63'd0, ap_done}, 64'd0);
        end
        ap_rst_n = 1'b0;
        #1;
        chk("rst_async", {59'd0, ap_idle, ap_done, ap_ready, B_i_ce0, B_i_address0 != 5'd0},
            {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_sum", {32'd0, sum_out}, 64'd0);
        chk("rst_total", {32'd0, dut.total}, 64'd0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge ap_clk);
            chk("abandoned_no_done", {63'd0, ap_done}, 64'd0);
        end
        chk("abandoned_sum", {32'd0, sum_out}, 64'd0);

        ap_start = 1'b1;
        begin
            int last_done = 0;
            int n_done    = 0;
            for (int c = 1; c <= 110; c++) begin
                @(negedge ap_clk);
                chk("b2b_done", {63'd0, ap_done}, {63'd0, (c == 33) || (c == 67) || (c == 101)});
                if (ap_done) begin
                    chk("b2b_sum", {32'd0, sum_out}, {32'd0, 32'd496});
                    if (n_done > 0)
                        chk("b2b_interval", 64'(c - last_done), 64'd34);
                    last_done = c;
                    n_done++;
                end
            end
            chk("b2b_count", 64'(n_done), 64'd3);
        end
        ap_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
